// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the default watchdog limit.
package uart_tx_arbiter_pkg;

  localparam int unsigned DEFAULT_TIMEOUT = 20000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Requester picker: finds the first valid requester searching upward from
// ptr with wraparound. Returns a one-hot grant plus its index.
// Build option UART_ARB_FIXED_PRIO_EN: lowest-index valid requester wins and
// ptr is ignored.
module rr_picker #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

`ifdef UART_ARB_FIXED_PRIO_EN
  logic ptr_unused;
  assign ptr_unused = ^ptr;

  // Fixed priority: the lowest valid index wins.
  always_comb begin
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && valid[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
  end
`else
  // Round robin: scan NREQ candidates starting at ptr, wrapping at NREQ-1.
  always_comb begin
    logic        found;
    int unsigned cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = (int'(ptr) + off) % NREQ;
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// UART transmit arbiter: shares one TX serializer among NREQ byte sources.
// One byte per grant; valid/ready toward sources, start/done toward the
// transmitter, watchdog abort with a sticky error flag.
// Build option UART_ARB_FIXED_PRIO_EN selects fixed (lowest-index) priority
// instead of round robin; the rotation pointer then stays at zero.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_done,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]   wd_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [IDX_W-1:0]  grant_id_q;
  logic              timeout_err_q;
  logic [NREQ-1:0]   pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              accept;
  logic              wd_expired;

  rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign req_ready   = (state_q == ST_IDLE) ? pick_grant : '0;
  assign accept      = |(req_ready & req_valid);
  assign wd_expired  = (state_q == ST_WAIT) && (wd_q == WD_W'(TIMEOUT - 1));
  assign tx_start    = (state_q == ST_START);
  assign busy        = (state_q != ST_IDLE);
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

`ifdef UART_ARB_FIXED_PRIO_EN
  assign rr_ptr_d = '0;
`else
  assign rr_ptr_d = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
`endif

  // Next-state logic: done or watchdog expiry both return to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (tx_done || wd_expired) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, latched byte/owner, rotation pointer, watchdog and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      wd_q          <= '0;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tx_data_q  <= req_data[pick_idx*DATA_W +: DATA_W];
        grant_id_q <= pick_idx;
        rr_ptr_q   <= rr_ptr_d;
      end
      if (state_q == ST_START) begin
        wd_q <= '0;
      end else if (state_q == ST_WAIT) begin
        wd_q <= wd_q + WD_W'(1);
      end
      // A done arriving on the expiry cycle wins over the watchdog.
      if (wd_expired && !tx_done) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (NREQ=3, DATA_W=8, TIMEOUT=16).
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ    = 3;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TIMEOUT = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*DATA_W-1:0]  req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_done;
  logic [1:0]              grant_id;
  logic                    busy;
  logic                    timeout_err;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_arbiter #(
    .NREQ    (NREQ),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] exp_b;
    logic [1:0] exp_id;

    reset = 1'b1; req_valid = '0; req_data = '0; tx_done = 1'b0;
    tick(); tick();
    chk("rst_ready",   32'(req_ready),   32'(0));
    chk("rst_start",   32'(tx_start),    32'(0));
    chk("rst_data",    32'(tx_data),     32'(0));
    chk("rst_gid",     32'(grant_id),    32'(0));
    chk("rst_busy",    32'(busy),        32'(0));
    chk("rst_err",     32'(timeout_err), 32'(0));
    reset = 1'b0;
    tick();

    // T1: single requester, done after 10 cycles
    req_valid = 3'b001; req_data = 24'h000041;
    #1;
    chk("t1_ready", 32'(req_ready), 32'(3'b001));
    tick();
    req_valid = '0;
    chk("t1_start",  32'(tx_start), 32'(1));
    chk("t1_data",   32'(tx_data),  32'(8'h41));
    chk("t1_gid",    32'(grant_id), 32'(0));
    chk("t1_ready0", 32'(req_ready), 32'(0));
    chk("t1_busy",   32'(busy),     32'(1));
    tick();
    chk("t1_start_once", 32'(tx_start), 32'(0));
    for (int i = 0; i < 9; i++) tick();
    chk("t1_hold", 32'(tx_data), 32'(8'h41));
    chk("t1_busy_wait", 32'(busy), 32'(1));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t1_idle", 32'(busy), 32'(0));
    chk("t1_err",  32'(timeout_err), 32'(0));

    // Restart rotation from pointer 0
    reset = 1'b1; tick(); reset = 1'b0;

    // T2: req0/req1 continuously valid
    req_valid = 3'b011; req_data = 24'h005AA5;
    for (int g = 0; g < 4; g++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
      exp_id = 2'd0;
`else
      exp_id = (g % 2 == 0) ? 2'd0 : 2'd1;
`endif
      exp_b = (exp_id == 2'd0) ? 8'hA5 : 8'h5A;
      #1;
      chk("t2_ready", 32'(req_ready), 32'(3'b001 << exp_id));
      tick();
      chk("t2_start", 32'(tx_start), 32'(1));
      chk("t2_data",  32'(tx_data),  32'(exp_b));
      chk("t2_gid",   32'(grant_id), 32'(exp_id));
      tick(); tick(); tick();
      chk("t2_noready_wait", 32'(req_ready), 32'(0));
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("t2_idle", 32'(busy), 32'(0));
    end
    req_valid = '0;

    // T5: stray done in IDLE, requester withdrawing before accept
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t5_busy",  32'(busy),     32'(0));
    chk("t5_start", 32'(tx_start), 32'(0));
    req_valid = 3'b010;
    #1;
    chk("t5_ready1", 32'(req_ready), 32'(3'b010));
    req_valid = '0;
    #1;
    chk("t5_ready_drop", 32'(req_ready), 32'(0));
    tick();
    chk("t5_noaccept", 32'(busy), 32'(0));
    tick();
    chk("t5_nostart", 32'(tx_start), 32'(0));
    req_valid = 3'b111;
    #1;
`ifdef UART_ARB_FIXED_PRIO_EN
    chk("t5_ptr", 32'(req_ready), 32'(3'b001));
`else
    chk("t5_ptr", 32'(req_ready), 32'(3'b100));
`endif
    req_valid = '0;
    #1;

    // T6: done on the expiry cycle counts as done
    req_valid = 3'b001; req_data = 24'h0000A5;
    tick();
    req_valid = '0;
    chk("t6_start", 32'(tx_start), 32'(1));
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("t6_busy_last", 32'(busy), 32'(1));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t6_idle", 32'(busy), 32'(0));
    chk("t6_err",  32'(timeout_err), 32'(0));

    // T3: no done, watchdog aborts 16 cycles after tx_start
    req_valid = 3'b001; req_data = 24'h000033;
    tick();
    req_valid = '0;
    chk("t3_start", 32'(tx_start), 32'(1));
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("t3_busy_last", 32'(busy), 32'(1));
    chk("t3_err_pre",   32'(timeout_err), 32'(0));
    tick();
    chk("t3_idle", 32'(busy), 32'(0));
    chk("t3_err",  32'(timeout_err), 32'(1));
    req_valid = 3'b010; req_data = 24'h007700;
    tick();
    req_valid = '0;
    chk("t3_good_data", 32'(tx_data),  32'(8'h77));
    chk("t3_good_gid",  32'(grant_id), 32'(1));
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t3_good_idle", 32'(busy), 32'(0));
    chk("t3_err_sticky", 32'(timeout_err), 32'(1));

    // T4: reset in WAIT
    req_valid = 3'b010; req_data = 24'h00C300;
    tick();
    req_valid = '0;
    chk("t4_data", 32'(tx_data), 32'(8'hC3));
    tick();
    chk("t4_wait", 32'(busy), 32'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_ready", 32'(req_ready),   32'(0));
    chk("t4_start", 32'(tx_start),    32'(0));
    chk("t4_data0", 32'(tx_data),     32'(0));
    chk("t4_gid",   32'(grant_id),    32'(0));
    chk("t4_busy",  32'(busy),        32'(0));
    chk("t4_err",   32'(timeout_err), 32'(0));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t4_stale_busy",  32'(busy),     32'(0));
    chk("t4_stale_start", 32'(tx_start), 32'(0));
    req_valid = 3'b111;
    #1;
    chk("t4_ptr0", 32'(req_ready), 32'(3'b001));
    req_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
